// File: rtl/conv_weight_pingpong_buf.sv
// Double-buffered conv weight store: words load into the shadow bank while the active bank
// streams one tap per beat (all channels packed) to the conv array.
module conv_weight_pingpong_buf #(
   parameter int unsigned CONV_CHANNEL = 4,
   parameter int unsigned KERNEL_SIZE  = 25,
   parameter int unsigned DATA_WIDTH   = 8,
   localparam int unsigned ADDR_WIDTH  = $clog2(KERNEL_SIZE),
   localparam int unsigned CH_WIDTH    = (CONV_CHANNEL > 1) ? $clog2(CONV_CHANNEL) : 1,
   localparam int unsigned OUT_WIDTH   = DATA_WIDTH * CONV_CHANNEL
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load_valid,
   output logic                  o_load_ready,
   input  logic [DATA_WIDTH-1:0] i_load_data,
   output logic                  o_load_done,
   input  logic                  i_rd_start,
   output logic                  o_rd_valid,
   input  logic                  i_rd_ready,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   output logic                  o_rd_last,
   output logic [OUT_WIDTH-1:0]  o_weight_out,
   output logic                  o_busy
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   logic [DATA_WIDTH-1:0] r_mem [2][CONV_CHANNEL][KERNEL_SIZE];

   state_t                r_state;
   logic                  r_active;
   logic                  r_active_valid;
   logic                  r_shadow_full;
   logic [CH_WIDTH-1:0]   r_ld_ch;
   logic [ADDR_WIDTH-1:0] r_ld_tap;
   logic [ADDR_WIDTH-1:0] r_iss_addr;
   logic                  r_iss_pending;
   logic                  r_load_ready;
   logic                  r_load_done;
   logic                  r_rd_valid;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic                  r_rd_last;
   logic [OUT_WIDTH-1:0]  r_weight;
   logic                  r_busy;

   logic                  w_load_hs;
   logic                  w_load_last;
   logic                  w_wr_bank;
   logic                  w_swap;
   logic                  w_start;
   logic                  w_rd_hs;
   logic                  w_issue;
   logic                  w_iss_last;
   logic [OUT_WIDTH-1:0]  w_rd_word;

   assign w_load_hs   = i_load_valid && r_load_ready;
   assign w_load_last = (r_ld_ch == CH_WIDTH'(CONV_CHANNEL - 1)) &&
                        (r_ld_tap == ADDR_WIDTH'(KERNEL_SIZE - 1));
   assign w_wr_bank   = ~r_active;
   assign w_swap      = r_shadow_full && (r_state == S_IDLE);
   assign w_start     = (r_state == S_IDLE) && i_rd_start && (r_active_valid || r_shadow_full);
   assign w_rd_hs     = r_rd_valid && i_rd_ready;
   // A tap is read only when the output register is free or draining, so it doubles as the hold stage
   assign w_issue     = (r_state == S_RUN) && r_iss_pending && (!r_rd_valid || i_rd_ready);
   assign w_iss_last  = (r_iss_addr == ADDR_WIDTH'(KERNEL_SIZE - 1));

   always_comb begin
      w_rd_word = '0;
      for (int c = 0; c < int'(CONV_CHANNEL); c++) begin
         w_rd_word[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_active][c][r_iss_addr];
      end
   end

   // Shadow-bank write port; contents intentionally not reset
   always_ff @(posedge i_clk) begin
      if (w_load_hs) begin
         r_mem[w_wr_bank][r_ld_ch][r_ld_tap] <= i_load_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_active       <= 1'b0;
         r_active_valid <= 1'b0;
         r_shadow_full  <= 1'b0;
         r_ld_ch        <= '0;
         r_ld_tap       <= '0;
         r_iss_addr     <= '0;
         r_iss_pending  <= 1'b0;
         r_load_ready   <= 1'b1;
         r_load_done    <= 1'b0;
         r_rd_valid     <= 1'b0;
         r_rd_addr      <= '0;
         r_rd_last      <= 1'b0;
         r_weight       <= '0;
         r_busy         <= 1'b0;
      end else begin
         r_load_done <= 1'b0;

         // Channel-major load counters; the final word closes the shadow bank
         if (w_load_hs) begin
            if (r_ld_tap == ADDR_WIDTH'(KERNEL_SIZE - 1)) begin
               r_ld_tap <= '0;
               r_ld_ch  <= w_load_last ? '0 : r_ld_ch + CH_WIDTH'(1);
            end else begin
               r_ld_tap <= r_ld_tap + ADDR_WIDTH'(1);
            end
            if (w_load_last) begin
               r_shadow_full <= 1'b1;
               r_load_ready  <= 1'b0;
               r_load_done   <= 1'b1;
            end
         end

         if (w_swap) begin
            r_active       <= ~r_active;
            r_active_valid <= 1'b1;
            r_shadow_full  <= 1'b0;
            r_load_ready   <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state       <= S_RUN;
                  r_busy        <= 1'b1;
                  r_iss_addr    <= '0;
                  r_iss_pending <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_issue) begin
                  r_rd_valid <= 1'b1;
                  r_rd_addr  <= r_iss_addr;
                  r_rd_last  <= w_iss_last;
                  r_weight   <= w_rd_word;
                  if (w_iss_last) begin
                     r_iss_pending <= 1'b0;
                  end else begin
                     r_iss_addr <= r_iss_addr + ADDR_WIDTH'(1);
                  end
               end else if (w_rd_hs) begin
                  r_rd_valid <= 1'b0;
                  r_rd_last  <= 1'b0;
                  if (r_rd_last) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_load_ready = r_load_ready;
   assign o_load_done  = r_load_done;
   assign o_rd_valid   = r_rd_valid;
   assign o_rd_addr    = r_rd_addr;
   assign o_rd_last    = r_rd_last;
   assign o_weight_out = r_weight;
   assign o_busy       = r_busy;

endmodule
